// File: rtl/comp_sd_adc_if.sv
// ----------------------------------------------------------------------------
// comp_sd_adc_if
// Sample output channel of the sigma-delta ADC back end.
//
// Handshake: the master raises sample_valid with sample_data. It holds both
// steady until a clk edge where sample_valid && sample_ready, which is the
// transfer. The slave may drive sample_ready at any time, independently of
// sample_valid.
//
// Signals:
//   sample_data  [DW-1:0] ones count of the last completed window
//   sample_valid          sample_data holds an unconsumed sample
//   sample_ready          downstream accepts the sample
// Modports: master (ADC side), slave (consumer side).
// ----------------------------------------------------------------------------
interface comp_sd_adc_if #(
    parameter int DW = 9
) ();
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/comp_sd_adc.sv
// ----------------------------------------------------------------------------
// comp_sd_adc
// First-order sigma-delta ADC back end for an SB_IO differential comparator.
// The raw comparator bit is synchronised. It is driven back out as the 1-bit
// feedback that closes the external RC loop. Ones are counted over a window of
// 2^WINDOW_LOG2 cycles, and each count is offered through a holding register.
//
// Optional build macro: CMPADC_MAJORITY_EN. When it is defined, a 3-sample
// majority filter sits after the synchroniser. This adds 1 cycle of latency
// and rejects single-cycle glitches.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on comp_in (>= 2)
//   WINDOW_LOG2  decimation window = 2^WINDOW_LOG2 cycles
//   SETTLE_LOG2  settle time after enable = 2^SETTLE_LOG2 cycles (>= 1)
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   en           conversion enable
//   comp_in      raw comparator bit, asynchronous to clk
//   fb_out       registered feedback bit to the RC network pin
//   overrun      sticky: a completed window was dropped
//   overrun_clr  clears overrun (a drop in the same cycle wins)
//   smp          sample channel (master side)
//   dbg_state_o  FSM state: 0 IDLE, 1 SETTLE, 2 RUN
// ----------------------------------------------------------------------------
module comp_sd_adc #(
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW_LOG2 = 8,
    parameter int SETTLE_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                comp_in,
    output logic                fb_out,
    output logic                overrun,
    input  logic                overrun_clr,
    comp_sd_adc_if.master       smp,
    output logic [1:0]          dbg_state_o
);
    localparam int AW = WINDOW_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic [SETTLE_LOG2-1:0]   settle_q, settle_d;
    logic [WINDOW_LOG2-1:0]   win_q, win_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic                     fb_q;
    logic [AW-1:0]            data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;

    logic                     comp_s;
    logic                     loop_bit;
    logic [AW-1:0]            result;
    logic                     new_result;
    logic                     xfer;

    assign comp_s = sync_q[SYNC_STAGES-1];

`ifdef CMPADC_MAJORITY_EN
    logic maj_d1_q, maj_d2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            maj_d1_q <= 1'b0;
            maj_d2_q <= 1'b0;
        end else begin
            maj_d1_q <= comp_s;
            maj_d2_q <= maj_d1_q;
        end
    end

    assign loop_bit = (comp_s & maj_d1_q) | (comp_s & maj_d2_q) | (maj_d1_q & maj_d2_q);
`else
    assign loop_bit = comp_s;
`endif

    // The window sum includes the current fb bit. On the last window cycle
    // this sum is the finished sample, and it is never wider than AW bits.
    assign result = acc_q + {{WINDOW_LOG2{1'b0}}, fb_q};

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        win_d      = win_q;
        acc_d      = acc_q;
        new_result = 1'b0;
        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                win_d    = '0;
                acc_d    = '0;
                if (en) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d  = ST_IDLE;
                    settle_d = '0;
                end else if (&settle_q) begin
                    state_d  = ST_RUN;
                    settle_d = '0;
                    win_d    = '0;
                    acc_d    = '0;
                end else begin
                    settle_d = settle_q + {{(SETTLE_LOG2-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                // Losing enable discards the partial window, even on its
                // last cycle.
                if (!en) begin
                    state_d = ST_IDLE;
                    win_d   = '0;
                    acc_d   = '0;
                end else if (&win_q) begin
                    new_result = 1'b1;
                    win_d      = '0;
                    acc_d      = '0;
                end else begin
                    win_d = win_q + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
                    acc_d = result;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output holding register. A transfer in the same cycle frees the slot for
    // the new result. Otherwise a new result finding the slot full is dropped.
    always_comb begin
        xfer    = valid_q & smp.sample_ready;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = overrun_clr ? 1'b0 : ovr_q;
        if (new_result) begin
            if (!valid_q || xfer) begin
                data_d  = result;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            settle_q <= '0;
            win_q    <= '0;
            acc_q    <= '0;
            fb_q     <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], comp_in};
            settle_q <= settle_d;
            win_q    <= win_d;
            acc_q    <= acc_d;
            fb_q     <= (state_q != ST_IDLE) ? loop_bit : 1'b0;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign fb_out           = fb_q;
    assign overrun          = ovr_q;
    assign smp.sample_data  = data_q;
    assign smp.sample_valid = valid_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_comp_sd_adc.sv
module tb_comp_sd_adc;
  localparam int SYNC   = 2;
  localparam int WL     = 4;
  localparam int SL     = 2;
  localparam int DW     = WL + 1;
  localparam int WIN    = 1 << WL;
  localparam int SETTLE = 1 << SL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic comp_in = 1'b0;
  logic overrun_clr = 1'b0;
  logic fb_out, overrun;
  logic [1:0] dbg_state;

  comp_sd_adc_if #(.DW(DW)) smp_if ();

  comp_sd_adc #(.SYNC_STAGES(SYNC), .WINDOW_LOG2(WL), .SETTLE_LOG2(SL)) dut (
    .clk(clk), .rst(rst), .en(en), .comp_in(comp_in), .fb_out(fb_out),
    .overrun(overrun), .overrun_clr(overrun_clr), .smp(smp_if),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 settling, 2 running.
  int         m_phase;
  int         m_settle;
  bit         m_bits[$];
  bit         m_dly[SYNC];
  bit         m_h1, m_h2;
  bit         m_fb;
  logic [DW-1:0] m_data;
  bit         m_valid, m_ovr;
  logic [DW-1:0] exp_q[$];
  int         n_xfer;

  task automatic model_reset();
    m_phase = 0; m_settle = 0; m_bits.delete();
    for (int i = 0; i < SYNC; i++) m_dly[i] = 1'b0;
    m_h1 = 1'b0; m_h2 = 1'b0; m_fb = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit r, input bit e, input bit c, input bit rd,
                            input bit cl, input logic [DW-1:0] pre_data);
    bit comp_s, lb, new_fb, have_res, xfer, drop;
    int res;
    if (r) begin
      model_reset();
      return;
    end
    comp_s = m_dly[SYNC-1];
`ifdef CMPADC_MAJORITY_EN
    lb = (int'(comp_s) + int'(m_h1) + int'(m_h2)) >= 2;
`else
    lb = comp_s;
`endif
    new_fb = (m_phase != 0) ? lb : 1'b0;
    have_res = 1'b0; res = 0; drop = 1'b0;
    case (m_phase)
      0: if (e) begin m_phase = 1; m_settle = 0; end
      1: if (!e) m_phase = 0;
         else begin
           m_settle++;
           if (m_settle == SETTLE) begin m_phase = 2; m_bits.delete(); end
         end
      default: if (!e) begin m_phase = 0; m_bits.delete(); end
         else begin
           m_bits.push_back(m_fb);
           if (m_bits.size() == WIN) begin
             foreach (m_bits[i]) res += int'(m_bits[i]);
             have_res = 1'b1;
             m_bits.delete();
           end
         end
    endcase
    xfer = m_valid && rd;
    if (xfer) begin
      n_xfer++;
      if (exp_q.size() == 0) check("xfer_empty", 32'd1, 32'd0);
      else check("xfer_data", 32'(pre_data), 32'(exp_q.pop_front()));
    end
    if (have_res) begin
      if (!m_valid || xfer) begin
        m_data = DW'(res); m_valid = 1'b1; exp_q.push_back(DW'(res));
      end else drop = 1'b1;
    end else if (xfer) m_valid = 1'b0;
    m_ovr = drop ? 1'b1 : (cl ? 1'b0 : m_ovr);
    m_h2 = m_h1; m_h1 = comp_s;
    for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = c;
    m_fb = new_fb;
  endtask

  // driver: one clock cycle with the given inputs, then compare
  task automatic step(input bit r, input bit e, input bit c, input bit rd, input bit cl);
    logic [DW-1:0] pre_data;
    @(negedge clk);
    rst = r; en = e; comp_in = c; smp_if.sample_ready = rd; overrun_clr = cl;
    pre_data = smp_if.sample_data;
    @(posedge clk);
    model_edge(r, e, c, rd, cl, pre_data);
    #1;
    check("fb_out", 32'(fb_out), 32'(m_fb));
    check("sample_valid", 32'(smp_if.sample_valid), 32'(m_valid));
    check("sample_data", 32'(smp_if.sample_data), 32'(m_data));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("state_idle", 32'(dbg_state == 2'd0), 32'(m_phase == 0));
  endtask

  int x0;
  bit tog;
  int dens;

  initial begin
    model_reset();
    n_xfer = 0;
    smp_if.sample_ready = 1'b1;

    // reset state
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 1: steady ones -> full-scale samples
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    x0 = n_xfer;
    for (int i = 0; i < 60; i++) step(0, 1, 1, 1, 0);
    check("s1_samples", 32'(n_xfer - x0 >= 2), 32'd1);
    check("s1_full", 32'(smp_if.sample_data), 32'(WIN));

    // 2: steady zeros
    for (int i = 0; i < 50; i++) step(0, 1, 0, 1, 0);
    check("s2_zero", 32'(smp_if.sample_data), 32'd0);
    check("s2_fb", 32'(fb_out), 32'd0);

    // 3: toggling every clock
    tog = 1'b0;
    for (int i = 0; i < 50; i++) begin step(0, 1, tog, 1, 0); tog = ~tog; end
`ifndef CMPADC_MAJORITY_EN
    check("s3_half", 32'(smp_if.sample_data), 32'(WIN / 2));
`endif

    // 4: stalled consumer across two window ends -> overrun
    for (int i = 0; i < 40; i++) step(0, 1, 1'($urandom_range(0, 1)), 0, 0);
    check("s4_overrun", 32'(overrun), 32'd1);
    check("s4_held", 32'(smp_if.sample_valid), 32'd1);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1);
    check("s4_clr", 32'(overrun), 32'd0);

    // 5: enable dropped mid-window, then re-enabled
    for (int i = 0; i < 7; i++) step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    check("s5_idle", 32'(dbg_state), 32'd0);
    step(0, 0, 1, 1, 0);
    check("s5_fb", 32'(fb_out), 32'd0);
    for (int i = 0; i < 50; i++) step(0, 1, 1'($urandom_range(0, 1)), 1, 0);

    // 6: reset while a sample is pending
    for (int i = 0; i < 30; i++) step(0, 1, 1, 0, 0);
    check("s6_pending", 32'(smp_if.sample_valid), 32'd1);
    step(1, 1, 1, 0, 0);
    check("s6_valid", 32'(smp_if.sample_valid), 32'd0);
    check("s6_data", 32'(smp_if.sample_data), 32'd0);

    // randomized: per-window density, random ready/clr, rare enable loss and reset
    dens = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % WIN == 0) dens = $urandom_range(0, 100);
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 99) != 0),
           ($urandom_range(1, 100) <= dens),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
